mshr_ctrl: RTL and testbench

Miss-status holding register file and miss sequencer for the L1 cache. It captures each primary miss flagged by the metadata next-state logic (mshr_alloc, way_out, wb_to_l2, is_evict). For each miss it issues an optional writeback (WR) and then a line request (RD for LD, RWITM for ST) to L2, and waits for the L2 response. It then hands a fill back to the tag/meta pipeline and returns mshr_hit to suppress secondary allocations.

---
 rtl/mshr_ctrl_pkg.sv | 35 +++
 rtl/mshr_ctrl_rr_arbiter.sv | 55 +++++
 rtl/mshr_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mshr_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mshr_ctrl_pkg.sv
// Shared L1 miss-handling definitions: op codes, MSHR entry states and
// line-address helper.
package mshr_ctrl_pkg;

   typedef enum logic [2:0] {
      NO_OP = 3'd0,
      LD    = 3'd1,
      ST    = 3'd2,
      RD    = 3'd3,
      WR    = 3'd4,
      RWITM = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WB_REQ = 3'd1,
      S_RD_REQ = 3'd2,
      S_WAIT   = 3'd3,
      S_FILL   = 3'd4
   } mshr_state_e;

   localparam int unsigned LINE_FN_W = 64;

   // Clears the offset bits; callers size-cast to their own address width.
   function automatic logic [LINE_FN_W-1:0] line_align(
      input logic [LINE_FN_W-1:0] addr,
      input int unsigned          offset_w
   );
      logic [LINE_FN_W-1:0] mask;
      mask = '1;
      mask = mask << offset_w;
      return addr & mask;
   endfunction

endpackage

// File: rtl/mshr_ctrl_rr_arbiter.sv
// Round-robin grant over a request vector; pointer advances past the winner
// on accept, and an unaccepted grant is locked until it is taken.
module mshr_ctrl_rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     i_req,
   input  logic             i_accept,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx,
   output logic [N-1:0]     o_grant
);

   logic [IDX_W-1:0] r_ptr;
   logic             r_hold;
   logic [IDX_W-1:0] r_hold_idx;
   logic [IDX_W-1:0] w_cand;
   logic [IDX_W-1:0] w_pick;
   logic             w_found;

   always_comb begin
      w_cand  = '0;
      w_pick  = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand = r_ptr + IDX_W'(k);
         if (!w_found && i_req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
      // A newly arriving request must not steal a grant that is still pending.
      o_valid = r_hold || w_found;
      o_idx   = r_hold ? r_hold_idx : w_pick;
      o_grant = '0;
      if (o_valid) o_grant[o_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr      <= '0;
         r_hold     <= 1'b0;
         r_hold_idx <= '0;
      end else if (o_valid && i_accept) begin
         r_ptr  <= o_idx + 1'b1;
         r_hold <= 1'b0;
      end else begin
         r_hold     <= o_valid;
         r_hold_idx <= o_idx;
      end
   end

endmodule

// File: rtl/mshr_ctrl.sv
// L1 miss-status holding registers: captures primary misses, sequences
// writeback/line requests to L2 and returns fills to the tag pipeline.
module mshr_ctrl
   import mshr_ctrl_pkg::*;
#(
   parameter int unsigned NUM_MSHR = 4,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned OFFSET_W = 6,
   parameter int unsigned ID_W     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_valid,
   input  logic [2:0]        alloc_op,
   input  logic [ADDR_W-1:0] alloc_addr,
   input  logic [3:0]        alloc_way,
   input  logic              alloc_wb,
   input  logic [ADDR_W-1:0] alloc_evict_addr,
   output logic [ID_W-1:0]   alloc_id,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              mshr_hit,
   output logic              full,
   output logic              l2_req_valid,
   output logic [2:0]        l2_req_op,
   output logic [ADDR_W-1:0] l2_req_addr,
   output logic [ID_W-1:0]   l2_req_id,
   input  logic              l2_req_ready,
   input  logic              l2_resp_valid,
   input  logic [ID_W-1:0]   l2_resp_id,
   output logic              fill_valid,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [3:0]        fill_way,
   output logic [2:0]        fill_op,
   output logic [ID_W-1:0]   fill_id,
   input  logic              fill_ready
);

   function automatic logic [ADDR_W-1:0] f_line(input logic [ADDR_W-1:0] a);
      return ADDR_W'(line_align(LINE_FN_W'(a), OFFSET_W));
   endfunction

   mshr_state_e       r_state     [NUM_MSHR];
   mshr_state_e       w_state_nxt [NUM_MSHR];
   logic [2:0]        r_op        [NUM_MSHR];
   logic [ADDR_W-1:0] r_addr      [NUM_MSHR];
   logic [ADDR_W-1:0] r_evict     [NUM_MSHR];
   logic [3:0]        r_way       [NUM_MSHR];
   logic              r_fill_hold;
   logic [ID_W-1:0]   r_fill_idx;

   logic              w_free_found;
   logic [ID_W-1:0]   w_free_idx;
   logic [ADDR_W-1:0] w_alloc_line;
   logic [ADDR_W-1:0] w_lookup_line;
   logic              w_alloc_match;
   logic              w_alloc_go;
   logic [NUM_MSHR-1:0] w_req_vec;
   logic              w_arb_valid;
   logic [ID_W-1:0]   w_arb_idx;
   logic [NUM_MSHR-1:0] w_arb_grant;
   logic              w_req_hs;
   logic              w_fill_any;
   logic [ID_W-1:0]   w_fill_lo;
   logic              w_fill_valid;
   logic [ID_W-1:0]   w_fill_idx;

   // Free-slot search and address matching use registered state only, so an
   // entry allocated or freed this cycle is invisible until the next one.
   always_comb begin
      w_free_found  = 1'b0;
      w_free_idx    = '0;
      w_alloc_match = 1'b0;
      mshr_hit      = 1'b0;
      w_req_vec     = '0;
      w_fill_any    = 1'b0;
      w_fill_lo     = '0;
      w_alloc_line  = f_line(alloc_addr);
      w_lookup_line = f_line(lookup_addr);
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
         if (r_state[i] == S_IDLE) begin
            if (!w_free_found) begin
               w_free_found = 1'b1;
               w_free_idx   = ID_W'(i);
            end
         end else begin
            if (r_addr[i] == w_alloc_line)  w_alloc_match = 1'b1;
            if (r_addr[i] == w_lookup_line) mshr_hit      = 1'b1;
         end
         w_req_vec[i] = (r_state[i] == S_WB_REQ) || (r_state[i] == S_RD_REQ);
         if (r_state[i] == S_FILL && !w_fill_any) begin
            w_fill_any = 1'b1;
            w_fill_lo  = ID_W'(i);
         end
      end
      full       = !w_free_found;
      w_alloc_go = alloc_valid && (alloc_op == LD || alloc_op == ST) &&
                   w_free_found && !w_alloc_match;
      alloc_id   = w_alloc_go ? w_free_idx : '0;
   end

   mshr_ctrl_rr_arbiter #(
      .N     (NUM_MSHR),
      .IDX_W (ID_W)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_req    (w_req_vec),
      .i_accept (l2_req_ready),
      .o_valid  (w_arb_valid),
      .o_idx    (w_arb_idx),
      .o_grant  (w_arb_grant)
   );

   assign w_req_hs     = w_arb_valid && l2_req_ready;
   assign w_fill_valid = r_fill_hold || w_fill_any;
   assign w_fill_idx   = r_fill_hold ? r_fill_idx : w_fill_lo;

   always_comb begin
      l2_req_valid = w_arb_valid;
      l2_req_op    = '0;
      l2_req_addr  = '0;
      l2_req_id    = '0;
      if (w_arb_valid) begin
         l2_req_id = w_arb_idx;
         if (r_state[w_arb_idx] == S_WB_REQ) begin
            l2_req_op   = WR;
            l2_req_addr = r_evict[w_arb_idx];
         end else begin
            l2_req_op   = (r_op[w_arb_idx] == ST) ? RWITM : RD;
            l2_req_addr = r_addr[w_arb_idx];
         end
      end
      fill_valid = w_fill_valid;
      fill_addr  = '0;
      fill_way   = '0;
      fill_op    = '0;
      fill_id    = '0;
      if (w_fill_valid) begin
         fill_addr = r_addr[w_fill_idx];
         fill_way  = r_way[w_fill_idx];
         fill_op   = r_op[w_fill_idx];
         fill_id   = w_fill_idx;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_MSHR; i++) begin
         w_state_nxt[i] = r_state[i];
         case (r_state[i])
            S_IDLE:
               if (w_alloc_go && w_free_idx == ID_W'(i))
                  w_state_nxt[i] = alloc_wb ? S_WB_REQ : S_RD_REQ;
            S_WB_REQ:
               if (w_req_hs && w_arb_grant[i]) w_state_nxt[i] = S_RD_REQ;
            S_RD_REQ:
               if (w_req_hs && w_arb_grant[i]) w_state_nxt[i] = S_WAIT;
            S_WAIT:
               if (l2_resp_valid && l2_resp_id == ID_W'(i)) w_state_nxt[i] = S_FILL;
            S_FILL:
               if (w_fill_valid && fill_ready && w_fill_idx == ID_W'(i))
                  w_state_nxt[i] = S_IDLE;
            default:
               w_state_nxt[i] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            r_state[i] <= S_IDLE;
            r_op[i]    <= '0;
            r_addr[i]  <= '0;
            r_evict[i] <= '0;
            r_way[i]   <= '0;
         end
         r_fill_hold <= 1'b0;
         r_fill_idx  <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_MSHR; i++) begin
            r_state[i] <= w_state_nxt[i];
         end
         if (w_alloc_go) begin
            r_op[w_free_idx]    <= alloc_op;
            r_addr[w_free_idx]  <= w_alloc_line;
            r_evict[w_free_idx] <= f_line(alloc_evict_addr);
            r_way[w_free_idx]   <= alloc_way;
         end
         r_fill_hold <= w_fill_valid && !fill_ready;
         r_fill_idx  <= w_fill_idx;
      end
   end

endmodule

// File: tb/tb_mshr_ctrl.sv
// Directed bench for mshr_ctrl: miss sequencing, writeback hold, secondary
// miss suppression, full/reuse, round-robin ordering and async reset.
module tb_mshr_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_valid;
   logic [2:0]  alloc_op;
   logic [31:0] alloc_addr;
   logic [3:0]  alloc_way;
   logic        alloc_wb;
   logic [31:0] alloc_evict_addr;
   logic [1:0]  alloc_id;
   logic [31:0] lookup_addr;
   logic        mshr_hit;
   logic        full;
   logic        l2_req_valid;
   logic [2:0]  l2_req_op;
   logic [31:0] l2_req_addr;
   logic [1:0]  l2_req_id;
   logic        l2_req_ready;
   logic        l2_resp_valid;
   logic [1:0]  l2_resp_id;
   logic        fill_valid;
   logic [31:0] fill_addr;
   logic [3:0]  fill_way;
   logic [2:0]  fill_op;
   logic [1:0]  fill_id;
   logic        fill_ready;

   int n_cmp = 0;
   int n_bad = 0;

   mshr_ctrl #(
      .NUM_MSHR (4),
      .ADDR_W   (32),
      .OFFSET_W (6),
      .ID_W     (2)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .alloc_valid      (alloc_valid),
      .alloc_op         (alloc_op),
      .alloc_addr       (alloc_addr),
      .alloc_way        (alloc_way),
      .alloc_wb         (alloc_wb),
      .alloc_evict_addr (alloc_evict_addr),
      .alloc_id         (alloc_id),
      .lookup_addr      (lookup_addr),
      .mshr_hit         (mshr_hit),
      .full             (full),
      .l2_req_valid     (l2_req_valid),
      .l2_req_op        (l2_req_op),
      .l2_req_addr      (l2_req_addr),
      .l2_req_id        (l2_req_id),
      .l2_req_ready     (l2_req_ready),
      .l2_resp_valid    (l2_resp_valid),
      .l2_resp_id       (l2_resp_id),
      .fill_valid       (fill_valid),
      .fill_addr        (fill_addr),
      .fill_way         (fill_way),
      .fill_op          (fill_op),
      .fill_id          (fill_id),
      .fill_ready       (fill_ready)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alloc_valid      = 1'b0;
      alloc_op         = 3'd0;
      alloc_addr       = '0;
      alloc_way        = 4'd0;
      alloc_wb         = 1'b0;
      alloc_evict_addr = '0;
      lookup_addr      = '0;
      l2_req_ready     = 1'b0;
      l2_resp_valid    = 1'b0;
      l2_resp_id       = 2'd0;
      fill_ready       = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Drives an allocation request and lets combinational outputs settle.
   task automatic set_alloc(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] way,
                            input logic wb, input logic [31:0] evict);
      alloc_valid      = 1'b1;
      alloc_op         = op;
      alloc_addr       = addr;
      alloc_way        = way;
      alloc_wb         = wb;
      alloc_evict_addr = evict;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #2;
      check_val("rst_alloc_id", alloc_id, 0);
      check_val("rst_full", full, 0);
      check_val("rst_req_valid", l2_req_valid, 0);
      check_val("rst_fill_valid", fill_valid, 0);
      check_val("rst_hit", mshr_hit, 0);
      tick();
      rst = 1'b0;

      // Load miss, clean victim
      set_alloc(3'd1, 32'h1040, 4'b0010, 1'b0, 32'h0);
      check_val("ld_alloc_id", alloc_id, 0);
      tick();
      alloc_valid = 1'b0;
      #1;
      check_val("ld_req_valid", l2_req_valid, 1);
      check_val("ld_req_op", l2_req_op, 3);
      check_val("ld_req_addr", l2_req_addr, 32'h1040);
      check_val("ld_req_id", l2_req_id, 0);
      l2_req_ready = 1'b1;
      tick();
      l2_req_ready = 1'b0;
      #1;
      check_val("ld_wait_noreq", l2_req_valid, 0);
      l2_resp_valid = 1'b1;
      l2_resp_id    = 2'd0;
      tick();
      l2_resp_valid = 1'b0;
      #1;
      check_val("ld_fill_valid", fill_valid, 1);
      check_val("ld_fill_addr", fill_addr, 32'h1040);
      check_val("ld_fill_way", fill_way, 4'b0010);
      check_val("ld_fill_op", fill_op, 1);
      check_val("ld_fill_id", fill_id, 0);
      fill_ready = 1'b1;
      tick();
      fill_ready = 1'b0;
      #1;
      check_val("ld_fill_done", fill_valid, 0);
      lookup_addr = 32'h1040;
      #1;
      check_val("ld_entry_idle", mshr_hit, 0);

      // Store miss, dirty victim; WR held while ready is low
      do_reset();
      set_alloc(3'd2, 32'h2000, 4'b0001, 1'b1, 32'h8000);
      check_val("st_alloc_id", alloc_id, 0);
      tick();
      alloc_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check_val("wr_hold_valid", l2_req_valid, 1);
         check_val("wr_hold_op", l2_req_op, 4);
         check_val("wr_hold_addr", l2_req_addr, 32'h8000);
         tick();
      end
      l2_req_ready = 1'b1;
      #1;
      check_val("wr_op", l2_req_op, 4);
      tick();
      #1;
      check_val("rwitm_op", l2_req_op, 7);
      check_val("rwitm_addr", l2_req_addr, 32'h2000);
      tick();
      l2_req_ready  = 1'b0;
      l2_resp_valid = 1'b1;
      l2_resp_id    = 2'd0;
      tick();
      l2_resp_valid = 1'b0;
      #1;
      check_val("st_fill_op", fill_op, 2);
      check_val("st_fill_way", fill_way, 4'b0001);

      // Secondary miss and illegal op
      do_reset();
      set_alloc(3'd1, 32'h1040, 4'b0100, 1'b0, 32'h0);
      tick();
      alloc_valid = 1'b0;
      lookup_addr = 32'h1078;
      #1;
      check_val("sec_hit", mshr_hit, 1);
      set_alloc(3'd1, 32'h1060, 4'b0100, 1'b0, 32'h0);
      check_val("sec_drop_id", alloc_id, 0);
      tick();
      lookup_addr = 32'h2000;
      set_alloc(3'd1, 32'h3000, 4'b0100, 1'b0, 32'h0);
      check_val("sec_nohit", mshr_hit, 0);
      check_val("sec_next_id", alloc_id, 1);
      tick();
      set_alloc(3'd3, 32'h7000, 4'b0100, 1'b0, 32'h0);
      check_val("badop_drop_id", alloc_id, 0);
      tick();
      set_alloc(3'd1, 32'h8000, 4'b0100, 1'b0, 32'h0);
      check_val("badop_next_id", alloc_id, 2);
      tick();
      alloc_valid = 1'b0;

      // Full and reuse
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_alloc(3'd1, 32'h1000 * (k + 1), 4'b1000, 1'b0, 32'h0);
         check_val("full_alloc_id", alloc_id, k);
         tick();
      end
      set_alloc(3'd1, 32'h5000, 4'b1000, 1'b0, 32'h0);
      check_val("full_flag", full, 1);
      check_val("full_5th_id", alloc_id, 0);
      tick();
      alloc_valid  = 1'b0;
      l2_req_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_val("full_grant", l2_req_id, k);
         tick();
      end
      l2_req_ready  = 1'b0;
      l2_resp_valid = 1'b1;
      l2_resp_id    = 2'd2;
      tick();
      l2_resp_valid = 1'b0;
      #1;
      check_val("reuse_fill_valid", fill_valid, 1);
      check_val("reuse_fill_id", fill_id, 2);
      check_val("reuse_fill_addr", fill_addr, 32'h3000);
      fill_ready = 1'b1;
      set_alloc(3'd1, 32'h6000, 4'b1000, 1'b0, 32'h0);
      check_val("reuse_same_cycle_full", full, 1);
      check_val("reuse_same_cycle_id", alloc_id, 0);
      tick();
      fill_ready = 1'b0;
      #1;
      check_val("reuse_full_clear", full, 0);
      check_val("reuse_id", alloc_id, 2);
      tick();
      alloc_valid = 1'b0;

      // Round-robin with entry 2 idle, then a stray response
      do_reset();
      set_alloc(3'd1, 32'h1000, 4'b0001, 1'b1, 32'h11000);
      check_val("rr_alloc0", alloc_id, 0);
      tick();
      set_alloc(3'd1, 32'h2000, 4'b0001, 1'b1, 32'h12000);
      check_val("rr_alloc1", alloc_id, 1);
      tick();
      set_alloc(3'd1, 32'h3000, 4'b0001, 1'b0, 32'h0);
      check_val("rr_alloc2", alloc_id, 2);
      tick();
      set_alloc(3'd1, 32'h4000, 4'b0001, 1'b1, 32'h14000);
      check_val("rr_alloc3", alloc_id, 3);
      tick();
      alloc_valid  = 1'b0;
      l2_req_ready = 1'b1;
      #1;
      check_val("rr_wr0_addr", l2_req_addr, 32'h11000);
      tick();
      check_val("rr_wr1_id", l2_req_id, 1);
      check_val("rr_wr1_op", l2_req_op, 4);
      tick();
      check_val("rr_rd2_id", l2_req_id, 2);
      check_val("rr_rd2_op", l2_req_op, 3);
      tick();
      check_val("rr_wr3_id", l2_req_id, 3);
      check_val("rr_wr3_addr", l2_req_addr, 32'h14000);
      tick();
      l2_req_ready  = 1'b0;
      l2_resp_valid = 1'b1;
      l2_resp_id    = 2'd2;
      tick();
      l2_resp_valid = 1'b0;
      #1;
      check_val("rr_fill2_id", fill_id, 2);
      fill_ready = 1'b1;
      tick();
      fill_ready   = 1'b0;
      l2_req_ready = 1'b1;
      #1;
      check_val("rr_g0_id", l2_req_id, 0);
      check_val("rr_g0_addr", l2_req_addr, 32'h1000);
      tick();
      check_val("rr_g1_id", l2_req_id, 1);
      check_val("rr_g1_addr", l2_req_addr, 32'h2000);
      tick();
      check_val("rr_g3_id", l2_req_id, 3);
      check_val("rr_g3_addr", l2_req_addr, 32'h4000);
      tick();
      l2_req_ready = 1'b0;
      #1;
      check_val("rr_all_waiting", l2_req_valid, 0);
      l2_resp_valid = 1'b1;
      l2_resp_id    = 2'd2;
      tick();
      l2_resp_valid = 1'b0;
      #1;
      check_val("stray_no_fill", fill_valid, 0);
      check_val("stray_no_req", l2_req_valid, 0);
      set_alloc(3'd1, 32'h5000, 4'b0001, 1'b0, 32'h0);
      check_val("stray_entry_idle", alloc_id, 2);
      tick();
      alloc_valid = 1'b0;

      // Async reset with entry 0 in WAIT and entry 1 requesting
      do_reset();
      set_alloc(3'd1, 32'h1040, 4'b0010, 1'b0, 32'h0);
      tick();
      alloc_valid  = 1'b0;
      l2_req_ready = 1'b1;
      tick();
      l2_req_ready = 1'b0;
      set_alloc(3'd2, 32'h2000, 4'b0001, 1'b0, 32'h0);
      tick();
      alloc_valid = 1'b0;
      lookup_addr = 32'h1040;
      #1;
      check_val("pre_rst_hit", mshr_hit, 1);
      check_val("pre_rst_req", l2_req_valid, 1);
      #1;
      rst = 1'b1;
      #1;
      check_val("arst_hit", mshr_hit, 0);
      check_val("arst_req_valid", l2_req_valid, 0);
      check_val("arst_req_addr", l2_req_addr, 0);
      check_val("arst_fill_valid", fill_valid, 0);
      check_val("arst_full", full, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_val("post_rst_req", l2_req_valid, 0);
      check_val("post_rst_hit", mshr_hit, 0);
      set_alloc(3'd1, 32'h3000, 4'b0001, 1'b0, 32'h0);
      check_val("post_rst_id", alloc_id, 0);
      tick();
      alloc_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
